// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen : program counter with branch/jump/call/return and circular RAS
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_gen #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter int                STEP      = 4,
  parameter int                RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             BR_TAKEN,
  input  logic [WIDTH-1:0] BR_TARGET,
  input  logic             JMP,
  input  logic             CALL,
  input  logic [WIDTH-1:0] JMP_TARGET,
  input  logic             RET,
  output logic [WIDTH-1:0] Data_out,
  output logic             VALID,
  output logic             RAS_EMPTY,
  output logic             RAS_FULL,
  output logic             RAS_UFLOW,
  output logic             MISALIGN
);

  localparam int               PTR_W      = $clog2(RAS_DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_W - WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             uflow_q, uflow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [WIDTH-1:0] pc_seq;
  logic [PTR_W-1:0] top_idx;
  logic             ras_empty;
  logic             ras_full;

  assign pc_seq    = pc_q + STEP_W;
  assign top_idx   = ptr_q - PTR_W'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);

  // ptr_q names the slot the next push writes; the top entry sits just below it.
  always_comb begin
    pc_d    = pc_q;
    valid_d = 1'b1;
    uflow_d = uflow_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ras_d   = ras_q;

    if (!valid_q) begin
      // Reset-exit edge: raise VALID only, so RESET_VEC is the first fetched PC.
      pc_d = pc_q;
    end else if (BR_TAKEN) begin
      pc_d = BR_TARGET;
    end else if (EN) begin
      if (RET && !ras_empty) begin
        pc_d = ras_q[top_idx];
        if (CALL) begin
          ras_d[top_idx] = pc_seq;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          ptr_d = top_idx;
        end
      end else if (RET) begin
        uflow_d = 1'b1;
        if (CALL) begin
          pc_d         = JMP_TARGET;
          ras_d[ptr_q] = pc_seq;
          ptr_d        = ptr_q + PTR_W'(1);
          cnt_d        = CNT_W'(1);
        end else begin
          pc_d = pc_seq;
        end
      end else if (JMP || CALL) begin
        pc_d = JMP_TARGET;
        if (CALL) begin
          // A full stack loses its oldest entry: that is the slot ptr_q names.
          ras_d[ptr_q] = pc_seq;
          ptr_d        = ptr_q + PTR_W'(1);
          if (!ras_full) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end else begin
        pc_d = pc_seq;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      uflow_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      uflow_q <= uflow_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    ras_q <= ras_d;
  end

  assign Data_out  = pc_q;
  assign VALID     = valid_q;
  assign RAS_EMPTY = ras_empty;
  assign RAS_FULL  = ras_full;
  assign RAS_UFLOW = uflow_q;
  assign MISALIGN  = |(pc_q & ALIGN_MASK);

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: queue-based reference model checked every cycle on a
// 32-bit and an 8-bit instance, plus directed literal expectations.
`default_nettype none

module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jmp = 1'b0;
  logic        call = 1'b0;
  logic [31:0] jmp_target = '0;
  logic        ret = 1'b0;

  logic [31:0] pc32;
  logic        valid32, empty32, full32, uflow32, mis32;
  logic [7:0]  pc8;
  logic        valid8, empty8, full8, uflow8, mis8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .BR_TAKEN(br_taken), .BR_TARGET(br_target),
    .JMP(jmp), .CALL(call), .JMP_TARGET(jmp_target), .RET(ret),
    .Data_out(pc32), .VALID(valid32), .RAS_EMPTY(empty32), .RAS_FULL(full32),
    .RAS_UFLOW(uflow32), .MISALIGN(mis32)
  );

  pc_gen #(.WIDTH(8), .RESET_VEC(8'h00), .STEP(4), .RAS_DEPTH(4)) dut8 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .BR_TAKEN(br_taken), .BR_TARGET(br_target[7:0]),
    .JMP(jmp), .CALL(call), .JMP_TARGET(jmp_target[7:0]), .RET(ret),
    .Data_out(pc8), .VALID(valid8), .RAS_EMPTY(empty8), .RAS_FULL(full8),
    .RAS_UFLOW(uflow8), .MISALIGN(mis8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC as a plain number, RAS as a bounded queue (back = top).
  logic [31:0] m_pc = '0;
  bit          m_valid = 1'b0;
  bit          m_uflow = 1'b0;
  bit          m_known = 1'b0;
  logic [31:0] m_ras [$];

  task automatic m_push(input logic [31:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > 4) void'(m_ras.pop_front());
  endtask

  always @(posedge clk) begin
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (!rst_n) begin
      m_pc = 32'h0; m_valid = 1'b0; m_uflow = 1'b0; m_known = 1'b1;
      m_ras.delete();
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (br_taken) begin
      m_pc = br_target;
    end else if (en) begin
      if (ret && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
        if (call) m_push(seq);
      end else if (ret) begin
        m_uflow = 1'b1;
        if (call) begin m_pc = jmp_target; m_push(seq); end
        else m_pc = seq;
      end else if (call) begin
        m_pc = jmp_target; m_push(seq);
      end else if (jmp) begin
        m_pc = jmp_target;
      end else begin
        m_pc = seq;
      end
    end
  end

  // Modulo-256 arithmetic commutes with every PC operation, so the 8-bit
  // instance must always show the low byte of the 32-bit model.
  always @(negedge clk) begin
    if (m_known) begin
      chk("pc32",    pc32,    m_pc);
      chk("valid32", {31'b0, valid32}, {31'b0, m_valid});
      chk("empty32", {31'b0, empty32}, {31'b0, m_ras.size() == 0});
      chk("full32",  {31'b0, full32},  {31'b0, m_ras.size() == 4});
      chk("uflow32", {31'b0, uflow32}, {31'b0, m_uflow});
      chk("mis32",   {31'b0, mis32},   {31'b0, m_pc[1:0] != 2'b00});
      chk("pc8",     {24'b0, pc8},     {24'b0, m_pc[7:0]});
      chk("valid8",  {31'b0, valid8},  {31'b0, m_valid});
      chk("empty8",  {31'b0, empty8},  {31'b0, m_ras.size() == 0});
      chk("full8",   {31'b0, full8},   {31'b0, m_ras.size() == 4});
      chk("uflow8",  {31'b0, uflow8},  {31'b0, m_uflow});
      chk("mis8",    {31'b0, mis8},    {31'b0, m_pc[1:0] != 2'b00});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    br_taken = 1'b1; br_target = t;
    cyc();
    br_taken = 1'b0;
  endtask

  initial begin
    logic [31:0] ret_exp [4];
    ret_exp[0] = 32'h404; ret_exp[1] = 32'h304; ret_exp[2] = 32'h204; ret_exp[3] = 32'h104;

    cyc(); cyc();
    chk("rst_pc", pc32, 32'h0);
    chk("rst_valid", {31'b0, valid32}, 32'h0);
    chk("rst_empty", {31'b0, empty32}, 32'h1);

    // Sequential run out of reset
    rst_n = 1'b1; en = 1'b1;
    cyc(); chk("seq0", pc32, 32'h0); chk("seq0_valid", {31'b0, valid32}, 32'h1);
    cyc(); chk("seq1", pc32, 32'h4);
    cyc(); chk("seq2", pc32, 32'h8);
    cyc(); chk("seq3", pc32, 32'hC);
    cyc(); chk("seq4", pc32, 32'h10);

    // Stall, then branch overriding the stall
    en = 1'b0;
    cyc(); chk("stall1", pc32, 32'h10);
    cyc(); chk("stall2", pc32, 32'h10);
    redirect(32'h80); chk("br_stall", pc32, 32'h80);
    en = 1'b1;

    // Call / return
    jmp = 1'b1; jmp_target = 32'h20; cyc(); jmp = 1'b0;
    chk("jmp20", pc32, 32'h20);
    call = 1'b1; jmp_target = 32'h100; cyc(); call = 1'b0;
    chk("call_pc", pc32, 32'h100); chk("call_empty", {31'b0, empty32}, 32'h0);
    cyc(); cyc();
    ret = 1'b1; cyc(); ret = 1'b0;
    chk("ret_pc", pc32, 32'h24); chk("ret_empty", {31'b0, empty32}, 32'h1);

    // Overflow: five calls into a four-entry stack
    redirect(32'h0);
    call = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      jmp_target = 32'h100 * i;
      cyc();
    end
    call = 1'b0;
    chk("ovf_full", {31'b0, full32}, 32'h1);
    ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("ovf_ret", pc32, ret_exp[i]);
    end
    ret = 1'b0;
    chk("ovf_empty", {31'b0, empty32}, 32'h1);

    // Underflow, wrap, misalignment
    redirect(32'h40);
    ret = 1'b1; cyc(); ret = 1'b0;
    chk("uflow_pc", pc32, 32'h44); chk("uflow_set", {31'b0, uflow32}, 32'h1);
    cyc(); chk("uflow_sticky", {31'b0, uflow32}, 32'h1);
    redirect(32'hFC);
    cyc(); chk("wrap8", {24'b0, pc8}, 32'h0); chk("nowrap32", pc32, 32'h100);
    redirect(32'h82); chk("misalign", {31'b0, mis32}, 32'h1);
    cyc(); chk("mis_seq", pc32, 32'h86);

    // Simultaneous RET+CALL with and without stack contents
    redirect(32'h1000);
    call = 1'b1; jmp_target = 32'h2000; cyc();
    ret = 1'b1; jmp_target = 32'h3000; cyc();
    chk("rc_pc", pc32, 32'h1004); chk("rc_notempty", {31'b0, empty32}, 32'h0);
    call = 1'b0; cyc();
    chk("rc_pop", pc32, 32'h2004); chk("rc_empty", {31'b0, empty32}, 32'h1);
    call = 1'b1; jmp_target = 32'h3000; cyc();
    chk("rc0_pc", pc32, 32'h3000); chk("rc0_empty", {31'b0, empty32}, 32'h0);
    call = 1'b0; cyc();
    chk("rc0_ret", pc32, 32'h2008);
    ret = 1'b0;

    // Branch suppresses call/ret; stall suppresses call; jump leaves stack
    call = 1'b1; jmp_target = 32'h600; br_taken = 1'b1; br_target = 32'h500; cyc();
    br_taken = 1'b0;
    chk("br_call", pc32, 32'h500); chk("br_call_empty", {31'b0, empty32}, 32'h1);
    en = 1'b0; cyc(); chk("stall_call", pc32, 32'h500);
    en = 1'b1; cyc(); call = 1'b0;
    chk("call600", pc32, 32'h600);
    jmp = 1'b1; jmp_target = 32'h700; cyc(); jmp = 1'b0;
    ret = 1'b1; br_taken = 1'b1; br_target = 32'h800; cyc(); br_taken = 1'b0;
    chk("br_ret", pc32, 32'h800);
    cyc(); ret = 1'b0;
    chk("jmp_keep", pc32, 32'h504);

    // Reset mid-operation with two stacked entries and stall asserted
    call = 1'b1; jmp_target = 32'h900; cyc(); jmp_target = 32'hA00; cyc(); call = 1'b0;
    en = 1'b0; br_taken = 1'b1; br_target = 32'hB00; rst_n = 1'b0;
    cyc();
    chk("mrst_pc", pc32, 32'h0); chk("mrst_valid", {31'b0, valid32}, 32'h0);
    chk("mrst_empty", {31'b0, empty32}, 32'h1); chk("mrst_uflow", {31'b0, uflow32}, 32'h0);
    br_taken = 1'b0; rst_n = 1'b1; en = 1'b1;
    cyc(); chk("exit_pc", pc32, 32'h0); chk("exit_valid", {31'b0, valid32}, 32'h1);
    cyc(); chk("exit_seq", pc32, 32'h4);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
- REQ-001 Parameters SHALL be:
  - WIDTH, default 32, PC width in bits.
  - RESET_VEC, default 0, PC value loaded at reset.
  - STEP, default 4, sequential increment; power of two, at least 1.
  - RAS_DEPTH, default 4, return-address-stack entries; power of two, at least 2.
- REQ-002 Ports SHALL be, as name / direction / width / meaning:
  - CLK, in, 1, the single clock; all state updates on the rising edge.
  - RST_N, in, 1, reset; synchronous and active-low.
  - EN, in, 1, advance enable; 0 = stall.
  - BR_TAKEN, in, 1, branch or flush redirect.
  - BR_TARGET, in, WIDTH, branch target.
  - JMP, in, 1, unconditional jump.
  - CALL, in, 1, jump and push the return address; CALL=1 implies a jump to JMP_TARGET.
  - JMP_TARGET, in, WIDTH, jump/call target.
  - RET, in, 1, return; pop the RAS and jump to the popped value.
  - Data_out, out, WIDTH, current PC.
  - VALID, out, 1, Data_out is a fetchable PC.
  - RAS_EMPTY, out, 1, RAS holds 0 entries.
  - RAS_FULL, out, 1, RAS holds RAS_DEPTH entries.
  - RAS_UFLOW, out, 1, sticky: a RET was issued with the RAS empty.
  - MISALIGN, out, 1, Data_out is not a multiple of STEP.

Function
- REQ-003 The next PC SHALL be selected by fixed priority:
  - BR_TAKEN -> BR_TARGET;
  - else EN=0 -> hold;
  - else RET -> top of RAS;
  - else JMP or CALL -> JMP_TARGET;
  - else Data_out+STEP.
- REQ-004 BR_TAKEN SHALL override a stall: the redirect takes effect even with EN=0.
- REQ-005 With EN=0 and BR_TAKEN=0, Data_out, the RAS contents, the RAS count and the flags SHALL be unchanged.
- REQ-006 PC arithmetic SHALL be modulo 2^WIDTH; 2^WIDTH-STEP advances to 0 with no flag.
- REQ-007 The latency SHALL be one cycle: a selection made in cycle n appears on Data_out in cycle n+1.
- REQ-008 The RAS SHALL be a circular LIFO with a top pointer and a count of 0..RAS_DEPTH.
- REQ-009 A CALL that takes effect SHALL push Data_out+STEP (modulo 2^WIDTH).
- REQ-010 A push when full SHALL overwrite the oldest entry, advance the pointer, and leave the count at RAS_DEPTH.
- REQ-011 A RET that takes effect with count>0 SHALL jump to the top entry and decrement the count.
- REQ-012 A RET that takes effect with count=0 SHALL take the sequential PC (Data_out+STEP), set RAS_UFLOW, and leave the count at 0.
- REQ-013 When RET and CALL take effect in the same cycle, the SHALL behaviour is:
  - jump to the popped top;
  - write Data_out+STEP into the same slot;
  - count unchanged.
- REQ-014 If that RET+CALL cycle has count=0, it SHALL:
  - behave as a CALL to JMP_TARGET (push, count becomes 1);
  - set RAS_UFLOW.
- REQ-015 BR_TAKEN SHALL suppress any CALL or RET in the same cycle; the RAS is unchanged.
- REQ-016 JMP without CALL SHALL NOT modify the RAS.
- REQ-017 RAS_EMPTY SHALL equal (count==0), RAS_FULL SHALL equal (count==RAS_DEPTH), and both SHALL be combinational from registered state.
- REQ-018 MISALIGN SHALL be combinational: (Data_out mod STEP) != 0; it SHALL NOT affect PC selection.
- REQ-019 RAS_UFLOW SHALL be cleared only by reset.

Reset
- REQ-020 While RST_N=0 is sampled on a CLK rising edge, the block SHALL set:
  - Data_out=RESET_VEC;
  - VALID=0;
  - RAS count=0 and pointer=0;
  - RAS_UFLOW=0.
  Entry contents are don't-care.
- REQ-021 Reset SHALL take priority over every other input, including mid-stall and mid-redirect.
- REQ-022 VALID SHALL become 1 at the first edge with RST_N=1 and then stay 1 until the next reset.
- REQ-023 Data_out SHALL hold RESET_VEC for the first VALID cycle, i.e. no increment occurs on the reset-exit edge.

Verification
- REQ-024 Sequential run: defaults, release reset, EN=1 for 4 cycles -> Data_out = 0, 4, 8, 12; VALID=1 from the first cycle.
- REQ-025 Stall vs. branch, at PC=0x10:
  - EN=0 for 2 cycles -> PC stays 0x10;
  - then EN=0 with BR_TAKEN=1 and BR_TARGET=0x80 -> PC=0x80 the next cycle.
- REQ-026 Call/return:
  - at PC=0x20, CALL with JMP_TARGET=0x100 -> PC=0x100, RAS_EMPTY=0;
  - 2 sequential cycles, then RET -> PC=0x24, RAS_EMPTY=1.
- REQ-027 Overflow: 5 CALLs from PCs 0x0, 0x100, 0x200, 0x300, 0x400 with RAS_DEPTH=4 -> RAS_FULL=1; 4 RETs return 0x404, 0x304, 0x204, 0x104, then RAS_EMPTY=1.
- REQ-028 Underflow and wrap:
  - RET with empty RAS at PC=0x40 -> PC=0x44 and RAS_UFLOW=1 (sticky);
  - with WIDTH=8, PC=0xFC -> next PC=0x00;
  - BR_TARGET=0x82 -> MISALIGN=1.
- REQ-029 Reset mid-operation: with RAS count=2 and EN=0, RST_N=0 for 1 cycle -> Data_out=RESET_VEC, VALID=0, RAS_EMPTY=1, RAS_UFLOW=0.
